// File: rtl/sram_port_arbiter.sv
// Two-port round-robin arbiter owning the asynchronous external SRAM pins.
// Each grant runs a fixed-length strobe window, one recovery cycle, then acks.
module sram_port_arbiter #(
  parameter int WAIT_CYCLES = 6,
  parameter int ADDR_W      = 23
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [1:0]        be0,
  input  logic [1:0]        be1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [15:0]       wdata0,
  input  logic [15:0]       wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [15:0]       rdata,
  output logic              busy,
  output logic              RamCS,
  output logic              MemOE,
  output logic              MemWR,
  output logic              RamLB,
  output logic              RamUB,
  output logic [ADDR_W-1:0] MemAdr,
  inout  wire  [15:0]       MemDB
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RECOVER} state_t;

  state_t              r_state, w_next;
  logic [3:0]          r_cnt;
  logic                r_last, r_gnt, r_we;
  logic [1:0]          r_be;
  logic [ADDR_W-1:0]   r_addr;
  logic [15:0]         r_wdata, r_rdata;
  logic                r_cs, r_oe, r_wr, r_lb, r_ub;

  logic                w_any, w_sel, w_sel_we, w_last_acc, w_acc_nx, w_we_nx, w_drive;
  logic [1:0]          w_sel_be, w_be_nx;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [15:0]         w_sel_wdata;

  // Contention goes to the port that did not win last; a lone requester always wins.
  assign w_any       = req0 | req1;
  assign w_sel       = (req0 & req1) ? ~r_last : req1;
  assign w_sel_we    = w_sel ? we1    : we0;
  assign w_sel_be    = w_sel ? be1    : be0;
  assign w_sel_addr  = w_sel ? addr1  : addr0;
  assign w_sel_wdata = w_sel ? wdata1 : wdata0;
  assign w_last_acc  = (r_cnt == 4'(WAIT_CYCLES));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_any) w_next = S_ACCESS;
      S_ACCESS:  if (w_last_acc) w_next = S_RECOVER;
      S_RECOVER: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state != S_IDLE);
    ack0    = (r_state == S_RECOVER) & ~r_gnt;
    ack1    = (r_state == S_RECOVER) &  r_gnt;
    w_drive = r_we & (r_state != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_last  <= 1'b1;
      r_gnt   <= 1'b0;
      r_we    <= 1'b0;
      r_be    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_any) begin
          r_gnt   <= w_sel;
          r_last  <= w_sel;
          r_we    <= w_sel_we;
          r_be    <= w_sel_be;
          r_addr  <= w_sel_addr;
          r_wdata <= w_sel_wdata;
          r_cnt   <= 4'd1;
        end
        S_ACCESS: begin
          if (!w_last_acc) r_cnt <= r_cnt + 4'd1;
          else if (!r_we)  r_rdata <= MemDB;
        end
        default: r_cnt <= '0;
      endcase
    end
  end

  // Strobes are registered from the next state so they align with ACCESS cycles.
  assign w_acc_nx = (w_next == S_ACCESS);
  assign w_we_nx  = (r_state == S_IDLE) ? w_sel_we : r_we;
  assign w_be_nx  = (r_state == S_IDLE) ? w_sel_be : r_be;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs <= 1'b1;
      r_oe <= 1'b1;
      r_wr <= 1'b1;
      r_lb <= 1'b1;
      r_ub <= 1'b1;
    end else begin
      r_cs <= ~w_acc_nx;
      r_oe <= ~(w_acc_nx & ~w_we_nx);
      r_wr <= ~(w_acc_nx &  w_we_nx);
      r_lb <= ~(w_acc_nx &  w_be_nx[0]);
      r_ub <= ~(w_acc_nx &  w_be_nx[1]);
    end
  end

  assign RamCS  = r_cs;
  assign MemOE  = r_oe;
  assign MemWR  = r_wr;
  assign RamLB  = r_lb;
  assign RamUB  = r_ub;
  assign MemAdr = r_addr;
  assign rdata  = r_rdata;
  // Write data stays on the bus through RECOVER for hold time after MemWR rises.
  assign MemDB  = w_drive ? r_wdata : 16'hzzzz;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a small byte-enabled async SRAM model.
module tb_sram_port_arbiter;
  localparam int W = 6;
  localparam int AW = 23;

  logic clk = 1'b0, rst_n;
  logic req0, req1, we0, we1;
  logic [1:0] be0, be1;
  logic [AW-1:0] addr0, addr1;
  logic [15:0] wdata0, wdata1;
  logic ack0, ack1, busy, RamCS, MemOE, MemWR, RamLB, RamUB;
  logic [15:0] rdata;
  logic [AW-1:0] MemAdr;
  wire  [15:0] MemDB;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sram_port_arbiter #(.WAIT_CYCLES(W), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy), .RamCS(RamCS), .MemOE(MemOE),
    .MemWR(MemWR), .RamLB(RamLB), .RamUB(RamUB), .MemAdr(MemAdr), .MemDB(MemDB)
  );

  // SRAM model: 16 words, contents reloaded on every reset.
  logic [15:0] mem [0:15];
  logic        mdrv;
  assign mdrv  = !RamCS && !MemOE && MemWR;
  assign MemDB = mdrv ? mem[MemAdr[3:0]] : 16'hzzzz;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) mem[i] <= 16'h0000;
      mem[5] <= 16'hBEEF;
      mem[7] <= 16'h1111;
      mem[3] <= 16'h5555;
    end else if (!RamCS && !MemWR) begin
      if (!RamLB) mem[MemAdr[3:0]][7:0]  <= MemDB[7:0];
      if (!RamUB) mem[MemAdr[3:0]][15:8] <= MemDB[15:8];
    end
  end

  typedef struct {
    logic        port;
    logic        we;
    logic [1:0]  be;
    logic [AW-1:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    int          exp_oe_cyc;
    int          exp_wr_cyc;
    int          exp_lb_cyc;
    int          exp_ub_cyc;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Watches one access already requested; returns at the IDLE cycle after ack.
  task automatic monitor(input vec_t v);
    int c = 0, ack_cyc = -1, n_cs = 0, n_oe = 0, n_wr = 0, n_lb = 0, n_ub = 0;
    int n_adr = 0, n_db = 0;
    while (ack_cyc < 0 && c < 40) begin
      @(negedge clk);
      c++;
      if (!RamCS) begin
        n_cs++;
        if (!MemOE) n_oe++;
        if (!MemWR) n_wr++;
        if (!RamLB) n_lb++;
        if (!RamUB) n_ub++;
        if (MemAdr !== v.addr) n_adr++;
        if (v.we && MemDB === v.wdata) n_db++;
      end
      if (ack0 || ack1) begin
        ack_cyc = c;
        chk("ack_port", {ack1, ack0}, v.port ? 2'b10 : 2'b01);
        chk("ack_strobes", {RamCS, MemOE, MemWR, RamLB, RamUB}, 5'b11111);
        if (v.we) begin
          if (MemDB === v.wdata) n_db++;
        end else chk("rdata", rdata, v.exp_rdata);
        if (v.port) req1 = 1'b0; else req0 = 1'b0;
      end
    end
    chk("ack_cycle", ack_cyc, W + 1);
    chk("cs_cycles", n_cs, W);
    chk("oe_cycles", n_oe, v.exp_oe_cyc);
    chk("wr_cycles", n_wr, v.exp_wr_cyc);
    chk("lb_cycles", n_lb, v.exp_lb_cyc);
    chk("ub_cycles", n_ub, v.exp_ub_cyc);
    chk("addr_bad", n_adr, 0);
    if (v.we) chk("wdata_cycles", n_db, W + 1);
    @(negedge clk);
    chk("idle_after", {busy, ack0, ack1}, 3'b000);
  endtask

  task automatic run_access(input vec_t v);
    if (v.port) begin
      req1 = 1'b1; we1 = v.we; be1 = v.be; addr1 = v.addr; wdata1 = v.wdata;
    end else begin
      req0 = 1'b1; we0 = v.we; be0 = v.be; addr0 = v.addr; wdata0 = v.wdata;
    end
    monitor(v);
  endtask

  vec_t tbl [9];

  initial begin
    //          port we  be     addr    wdata     rdata    oe wr lb ub
    tbl[0] = '{1'b1, 1'b0, 2'b11, 23'h5, 16'h0000, 16'hBEEF, 6, 0, 6, 6};
    tbl[1] = '{1'b0, 1'b1, 2'b11, 23'h5, 16'h00A5, 16'h0000, 0, 6, 6, 6};
    tbl[2] = '{1'b1, 1'b0, 2'b11, 23'h5, 16'h0000, 16'h00A5, 6, 0, 6, 6};
    tbl[3] = '{1'b0, 1'b1, 2'b01, 23'h5, 16'h1234, 16'h0000, 0, 6, 6, 0};
    tbl[4] = '{1'b1, 1'b0, 2'b11, 23'h5, 16'h0000, 16'h0034, 6, 0, 6, 6};
    tbl[5] = '{1'b0, 1'b1, 2'b10, 23'h7, 16'hABCD, 16'h0000, 0, 6, 0, 6};
    tbl[6] = '{1'b1, 1'b0, 2'b10, 23'h7, 16'h0000, 16'hAB11, 6, 0, 0, 6};
    tbl[7] = '{1'b0, 1'b1, 2'b00, 23'h3, 16'hFFFF, 16'h0000, 0, 6, 0, 0};
    tbl[8] = '{1'b0, 1'b0, 2'b11, 23'h3, 16'h0000, 16'h5555, 6, 0, 6, 6};

    // Reset with random inputs toggling.
    rst_n = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req0 = 1'($urandom); req1 = 1'($urandom); we0 = 1'($urandom); we1 = 1'($urandom);
      be0 = 2'($urandom); be1 = 2'($urandom); addr0 = AW'($urandom); addr1 = AW'($urandom);
      wdata0 = 16'($urandom); wdata1 = 16'($urandom);
      @(negedge clk);
    end
    chk("rst_strobes", {RamCS, MemOE, MemWR, RamLB, RamUB}, 5'b11111);
    chk("rst_ack", {ack0, ack1}, 2'b00);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_adr", MemAdr, 0);
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; be0 = 0; be1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) run_access(tbl[i]);

    // Both ports held: strict alternation starting at port 0, 8 clocks apart.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    req0 = 1; we0 = 1; be0 = 2'b11; addr0 = 23'h2; wdata0 = 16'h0101;
    req1 = 1; we1 = 0; be1 = 2'b11; addr1 = 23'h2;
    begin
      int nack = 0, last_c = 0, dup = 0, bad_port = 0, bad_gap = 0, bad_rd = 0, first_c = -1;
      for (int c = 1; c <= 100 && nack < 8; c++) begin
        @(negedge clk);
        if (ack0 && ack1) dup++;
        if (ack0 || ack1) begin
          if (ack1 !== 1'(nack % 2)) bad_port++;
          if (nack == 0) first_c = c;
          else if (c - last_c != W + 2) bad_gap++;
          if (ack1 && rdata !== 16'h0101) bad_rd++;
          last_c = c;
          nack++;
          if (nack == 8) begin req0 = 0; req1 = 0; end
        end
      end
      chk("rr_acks", nack, 8);
      chk("rr_first", first_c, W + 1);
      chk("rr_order", bad_port, 0);
      chk("rr_gap", bad_gap, 0);
      chk("rr_dup", dup, 0);
      chk("rr_rdata", bad_rd, 0);
    end
    @(negedge clk);
    chk("rr_idle", busy, 1'b0);

    // Reset in ACCESS cycle 3: strobes release at once, no ack, request re-served.
    @(negedge clk);
    req0 = 1; we0 = 1; be0 = 2'b11; addr0 = 23'h9; wdata0 = 16'h7777;
    repeat (3) @(negedge clk);
    chk("mid_cs_active", RamCS, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_strobes", {RamCS, MemOE, MemWR, RamLB, RamUB}, 5'b11111);
    chk("mid_rst_ack", {ack0, ack1, busy}, 3'b000);
    @(negedge clk);
    chk("mid_rst_ack2", {ack0, ack1}, 2'b00);
    rst_n = 1'b1;
    monitor('{1'b0, 1'b1, 2'b11, 23'h9, 16'h7777, 16'h0000, 0, 6, 6, 6});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
